// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
//
// Sequencer that sits between the sample source (symbol mapper) and the
// OFDM FFT/IFFT core.  A start request makes it emit a single configuration
// beat (transform size, direction, scaling schedule) on the core's config
// AXI-Stream channel.  It then passes upstream samples straight through to
// the core's data channel.  Along the way it generates tlast every N samples,
// checks the upstream tlast against that framing, and counts completed frames.
//
// Optional build macro:
//   FFT_FRAME_ZERO_PAD_EN - when defined, an upstream tlast that arrives
//                           before the last sample of a frame stops upstream
//                           traffic. The rest of the frame is then filled
//                           with zero samples, so the core always sees
//                           complete N-point frames. When undefined, an early
//                           tlast is only flagged and forwarding continues.
//
// Parameters:
//   DATA_W    bits per I/Q component (sample tdata is {Q,I}, 2*DATA_W bits)
//   NFFT_LOG2 log2 of the transform size N (3..16)
//   CFG_W     config tdata width, at least 9+SCALE_W
//   FRAMES_W  width of the frame-count request and frame counter
//
// Ports:
//   aclk, aresetn            clock (rising edge) / async active-low reset
//   start                    one-cycle run request, honoured only when idle
//   fwd_inv                  1 = forward FFT, 0 = inverse (latched on start)
//   scale_sch                scaling schedule (latched on start)
//   num_frames               frames per run, 0 = run until stop (latched)
//   stop                     finish the current frame, then go idle
//   busy                     high whenever not idle
//   done                     one-cycle pulse in the first idle cycle of a run end
//   frame_cnt                frames completed in the current run (wraps)
//   err_tlast_early          pulse: upstream tlast before sample N-1
//   err_tlast_missing        pulse: upstream sample N-1 without tlast
//   s_axis_*                 upstream sample stream
//   m_axis_cfg_*             config stream to the FFT core
//   m_axis_data_*            sample stream to the FFT core
// ---------------------------------------------------------------------------
module fft_frame_ctrl #(
    parameter  int DATA_W    = 16,
    parameter  int NFFT_LOG2 = 6,
    parameter  int CFG_W     = 24,
    parameter  int FRAMES_W  = 8,
    localparam int SCALE_W   = 2 * ((NFFT_LOG2 + 1) / 2)
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  start,
    input  logic                  fwd_inv,
    input  logic [SCALE_W-1:0]    scale_sch,
    input  logic [FRAMES_W-1:0]   num_frames,
    input  logic                  stop,

    output logic                  busy,
    output logic                  done,
    output logic [FRAMES_W-1:0]   frame_cnt,
    output logic                  err_tlast_early,
    output logic                  err_tlast_missing,

    input  logic [2*DATA_W-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,

    output logic [CFG_W-1:0]      m_axis_cfg_tdata,
    output logic                  m_axis_cfg_tvalid,
    input  logic                  m_axis_cfg_tready,

    output logic [2*DATA_W-1:0]   m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic                  m_axis_data_tlast
);

    // The PAD state only exists in the zero-padding build.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        DATA = 2'd2
`ifdef FFT_FRAME_ZERO_PAD_EN
        ,
        PAD  = 2'd3
`endif
    } state_t;

    // All-ones is sample index N-1, so the counter wraps N-1 -> 0 by itself.
    localparam logic [NFFT_LOG2-1:0] CNT_LAST = '1;

    state_t                 state;
    logic [NFFT_LOG2-1:0]   cnt;
    logic [FRAMES_W-1:0]    num_frames_q;
    logic [FRAMES_W-1:0]    frame_cnt_next;
    logic                   stop_req;
    logic [CFG_W-1:0]       cfg_word;
    logic                   data_hs;
    logic                   at_last;
    logic                   frame_end;
    logic                   run_over;

    assign busy = (state != IDLE);

    // Config word layout expected by the core: size in [4:0], direction in
    // [8], scaling schedule directly above it, every other bit zero.
    always_comb begin
        cfg_word                = '0;
        cfg_word[4:0]           = 5'(NFFT_LOG2);
        cfg_word[8]             = fwd_inv;
        cfg_word[8+SCALE_W:9]   = scale_sch;
    end

    // A sample moves to the core when the core accepts it.  In DATA the
    // upstream valid is also needed.  In PAD the zero filler is always valid.
    always_comb begin
        data_hs = 1'b0;
        case (state)
            DATA:    data_hs = s_axis_tvalid && m_axis_data_tready;
`ifdef FFT_FRAME_ZERO_PAD_EN
            PAD:     data_hs = m_axis_data_tready;
`endif
            default: data_hs = 1'b0;
        endcase
    end

    assign at_last        = (cnt == CNT_LAST);
    assign frame_end      = data_hs && at_last;
    assign frame_cnt_next = frame_cnt + 1'b1;

    // A run ends at a frame boundary if stop is present now, or was seen at
    // any point since the start, or the requested frame count is reached.
    assign run_over = stop || stop_req ||
                      ((num_frames_q != '0) && (frame_cnt_next == num_frames_q));

    // Data path is a zero-latency combinational pass-through gated by state.
    // Outside DATA/PAD everything is held at zero, so an async reset forces
    // every stream output low immediately.
    always_comb begin
        s_axis_tready      = 1'b0;
        m_axis_data_tvalid = 1'b0;
        m_axis_data_tdata  = '0;
        m_axis_data_tlast  = 1'b0;
        case (state)
            DATA: begin
                s_axis_tready      = m_axis_data_tready;
                m_axis_data_tvalid = s_axis_tvalid;
                m_axis_data_tdata  = s_axis_tdata;
                m_axis_data_tlast  = at_last;
            end
`ifdef FFT_FRAME_ZERO_PAD_EN
            PAD: begin
                m_axis_data_tvalid = 1'b1;
                m_axis_data_tlast  = at_last;
            end
`endif
            default: begin
                s_axis_tready      = 1'b0;
                m_axis_data_tvalid = 1'b0;
            end
        endcase
    end

    // Control FSM with registered status outputs.  The frame-end handling is
    // placed after the per-state case, so that its state/done updates take
    // priority over anything the case assigned in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= IDLE;
            cnt               <= '0;
            frame_cnt         <= '0;
            num_frames_q      <= '0;
            stop_req          <= 1'b0;
            m_axis_cfg_tdata  <= '0;
            m_axis_cfg_tvalid <= 1'b0;
            done              <= 1'b0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
        end else begin
            done              <= 1'b0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        m_axis_cfg_tdata  <= cfg_word;
                        m_axis_cfg_tvalid <= 1'b1;
                        num_frames_q      <= num_frames;
                        // A stop arriving together with start is remembered
                        // and takes effect at the first frame end.
                        stop_req          <= stop;
                        frame_cnt         <= '0;
                        cnt               <= '0;
                        state             <= CFG;
                    end
                end

                CFG: begin
                    if (m_axis_cfg_tready) begin
                        m_axis_cfg_tvalid <= 1'b0;
                        state             <= DATA;
                    end
                end

                DATA: begin
                    if (data_hs) begin
                        cnt <= cnt + 1'b1;
                        if (s_axis_tlast && !at_last) begin
                            err_tlast_early <= 1'b1;
`ifdef FFT_FRAME_ZERO_PAD_EN
                            state           <= PAD;
`endif
                        end
                        if (!s_axis_tlast && at_last) begin
                            err_tlast_missing <= 1'b1;
                        end
                    end
                end

`ifdef FFT_FRAME_ZERO_PAD_EN
                PAD: begin
                    if (data_hs) begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase

            // Stop is a level that may be short.  It is latched so that it is
            // honoured at the next frame boundary, even after it drops.
            if ((state != IDLE) && stop) begin
                stop_req <= 1'b1;
            end

            if (frame_end) begin
                frame_cnt <= frame_cnt_next;
                if (run_over) begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    stop_req <= 1'b0;
                end else begin
                    state    <= DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_ctrl
//
// Self-checking bench for fft_frame_ctrl with N = 64.  Upstream samples are
// random.  Expected core-side beats, error pulse counts, frame counts and
// upstream consumption are derived from a frame-level reference model that
// walks the planned input list N samples at a time.  A monitor records
// every handshake on the output side.
// Honours FFT_FRAME_ZERO_PAD_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_fft_frame_ctrl;

    localparam int DATA_W    = 16;
    localparam int NFFT_LOG2 = 6;
    localparam int CFG_W     = 24;
    localparam int FRAMES_W  = 8;
    localparam int SCALE_W   = 2 * ((NFFT_LOG2 + 1) / 2);
    localparam int N         = 1 << NFFT_LOG2;
    localparam int DW        = 2 * DATA_W;

    logic                 aclk;
    logic                 aresetn;
    logic                 start;
    logic                 fwd_inv;
    logic [SCALE_W-1:0]   scale_sch;
    logic [FRAMES_W-1:0]  num_frames;
    logic                 stop;
    logic                 busy;
    logic                 done;
    logic [FRAMES_W-1:0]  frame_cnt;
    logic                 err_tlast_early;
    logic                 err_tlast_missing;
    logic [DW-1:0]        s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic [CFG_W-1:0]     m_axis_cfg_tdata;
    logic                 m_axis_cfg_tvalid;
    logic                 m_axis_cfg_tready;
    logic [DW-1:0]        m_axis_data_tdata;
    logic                 m_axis_data_tvalid;
    logic                 m_axis_data_tready;
    logic                 m_axis_data_tlast;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t              in_q[$];
    beat_t              exp_q[$];
    beat_t              out_q[$];
    logic [CFG_W-1:0]   cfg_q[$];

    int early_seen;
    int missing_seen;
    int done_seen;
    int overlap_seen;

    int checks;
    int errors;

    fft_frame_ctrl #(
        .DATA_W    (DATA_W),
        .NFFT_LOG2 (NFFT_LOG2),
        .CFG_W     (CFG_W),
        .FRAMES_W  (FRAMES_W)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .start              (start),
        .fwd_inv            (fwd_inv),
        .scale_sch          (scale_sch),
        .num_frames         (num_frames),
        .stop               (stop),
        .busy               (busy),
        .done               (done),
        .frame_cnt          (frame_cnt),
        .err_tlast_early    (err_tlast_early),
        .err_tlast_missing  (err_tlast_missing),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_cfg_tdata   (m_axis_cfg_tdata),
        .m_axis_cfg_tvalid  (m_axis_cfg_tvalid),
        .m_axis_cfg_tready  (m_axis_cfg_tready),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tready (m_axis_data_tready),
        .m_axis_data_tlast  (m_axis_data_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output-side monitor, sampled mid-cycle while the inputs are stable.
    initial begin
        early_seen   = 0;
        missing_seen = 0;
        done_seen    = 0;
        overlap_seen = 0;
    end

    always @(negedge aclk) begin : monitor
        beat_t mb;
        if (aresetn) begin
            if (m_axis_data_tvalid && m_axis_data_tready) begin
                mb.data = m_axis_data_tdata;
                mb.last = m_axis_data_tlast;
                out_q.push_back(mb);
            end
            if (m_axis_cfg_tvalid && m_axis_cfg_tready) cfg_q.push_back(m_axis_cfg_tdata);
            if (err_tlast_early)   early_seen++;
            if (err_tlast_missing) missing_seen++;
            if (done)              done_seen++;
            if (done && busy)      overlap_seen++;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Plan nfr frames of random samples.  If early_idx >= 0, the first frame
    // carries its tlast at early_idx instead of at N-1.
    task automatic build_frames(input int nfr, input int early_idx);
        beat_t b;
        for (int f = 0; f < nfr; f++) begin
            for (int i = 0; i < N; i++) begin
                b.data = DW'($urandom);
                b.last = (f == 0 && early_idx >= 0) ? (i == early_idx) : (i == N - 1);
                in_q.push_back(b);
            end
        end
    endtask

    // Reference model: walk the planned input N samples per frame.
    task automatic compute_expected(input int nf, input int stop_at,
                                    output int frames, output int n_early,
                                    output int n_missing, output int consumed);
        int idx;
        int early_at;
        beat_t b;
        exp_q.delete();
        idx = 0; frames = 0; n_early = 0; n_missing = 0;
        while (1) begin
            early_at = -1;
            for (int i = 0; i < N; i++) begin
`ifdef FFT_FRAME_ZERO_PAD_EN
                if (early_at >= 0) begin
                    b.data = '0;
                    b.last = (i == N - 1);
                    exp_q.push_back(b);
                    continue;
                end
`endif
                b = in_q[idx];
                idx++;
                if (b.last && i != N - 1) begin
                    n_early++;
                    if (early_at < 0) early_at = i;
                end
                if (!b.last && i == N - 1) n_missing++;
                b.last = (i == N - 1);
                exp_q.push_back(b);
            end
            frames++;
            if (stop_at >= 0 && idx > stop_at) break;
            if (nf != 0 && frames == nf) break;
            if (idx + N > in_q.size()) break;
        end
        consumed = idx;
    endtask

    task automatic do_start(input logic f, input logic [SCALE_W-1:0] sc,
                            input logic [FRAMES_W-1:0] nf, input logic with_stop);
        fwd_inv    = f;
        scale_sch  = sc;
        num_frames = nf;
        stop       = with_stop;
        start      = 1'b1;
        @(posedge aclk); #1;
        start      = 1'b0;
        stop       = 1'b0;
        fwd_inv    = ~f;
        scale_sch  = ~sc;
        num_frames = nf + 1'b1;
        check_output("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Drive the upstream queue and the core's ready signals until done is
    // seen, the cycle budget expires, or abort_at samples have been consumed.
    task automatic apply_stimulus(input int stop_at, input int start_again_at,
                                  input bit rand_bp, input int abort_at, input int max_cycles,
                                  output int consumed, output bit finished);
        int cyc;
        consumed = 0; cyc = 0; finished = 1'b0;
        while (!finished && cyc < max_cycles) begin
            if (in_q.size() > 0) begin
                s_axis_tdata  = in_q[0].data;
                s_axis_tlast  = in_q[0].last;
                s_axis_tvalid = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                s_axis_tdata  = '0;
                s_axis_tlast  = 1'b0;
                s_axis_tvalid = 1'b0;
            end
            m_axis_data_tready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axis_cfg_tready  = rand_bp ? ($urandom_range(0, 1) != 0) : 1'b1;
            stop  = (stop_at >= 0 && consumed >= stop_at);
            start = (cyc == start_again_at);
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                void'(in_q.pop_front());
                consumed++;
            end
            if (done) finished = 1'b1;
            @(posedge aclk); #1;
            cyc++;
            if (abort_at >= 0 && consumed >= abort_at) return;
        end
        s_axis_tvalid      = 1'b0;
        s_axis_tlast       = 1'b0;
        start              = 1'b0;
        stop               = 1'b0;
        m_axis_data_tready = 1'b1;
        m_axis_cfg_tready  = 1'b1;
    endtask

    // One complete run: model, start, stream, and compare everything.
    task automatic run_case(input string tag, input logic f, input logic [SCALE_W-1:0] sc,
                            input int nf, input int stop_at, input logic start_with_stop,
                            input int start_again_at, input bit rand_bp);
        int e_frames, e_early, e_missing, e_consumed;
        int out_base, cfg_base, early_base, missing_base, done_base;
        int consumed, n_out, data_bad, last_bad;
        bit finished;
        longint exp_cfg;

        compute_expected(nf, start_with_stop ? 0 : stop_at,
                         e_frames, e_early, e_missing, e_consumed);
        exp_cfg = longint'(NFFT_LOG2) + longint'(f) * 256 + longint'(sc) * 512;

        out_base     = out_q.size();
        cfg_base     = cfg_q.size();
        early_base   = early_seen;
        missing_base = missing_seen;
        done_base    = done_seen;

        do_start(f, sc, FRAMES_W'(nf), start_with_stop);
        apply_stimulus(stop_at, start_again_at, rand_bp, -1, 4000, consumed, finished);

        check_output({tag, "_finished"}, 64'(finished), 64'd1);
        check_output({tag, "_cfg_beats"}, 64'(cfg_q.size() - cfg_base), 64'd1);
        if (cfg_q.size() > cfg_base)
            check_output({tag, "_cfg_word"}, 64'(cfg_q[cfg_base]), 64'(exp_cfg));

        n_out = out_q.size() - out_base;
        check_output({tag, "_beats"}, 64'(n_out), 64'(exp_q.size()));
        data_bad = 0; last_bad = 0;
        for (int i = 0; i < n_out && i < exp_q.size(); i++) begin
            if (out_q[out_base + i].data !== exp_q[i].data) data_bad++;
            if (out_q[out_base + i].last !== exp_q[i].last) last_bad++;
        end
        check_output({tag, "_data_beats_wrong"}, 64'(data_bad), 64'd0);
        check_output({tag, "_tlast_beats_wrong"}, 64'(last_bad), 64'd0);
        check_output({tag, "_consumed"}, 64'(consumed), 64'(e_consumed));
        check_output({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(e_frames % (1 << FRAMES_W)));
        check_output({tag, "_done_pulses"}, 64'(done_seen - done_base), 64'd1);
        check_output({tag, "_err_early"}, 64'(early_seen - early_base), 64'(e_early));
        check_output({tag, "_err_missing"}, 64'(missing_seen - missing_base), 64'(e_missing));
        check_output({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check_output({tag, "_idle_after"}, 64'(busy), 64'd0);
        in_q.delete();
    endtask

    initial begin : stimulus
        int consumed;
        bit finished;

        checks = 0;
        errors = 0;
        aresetn            = 1'b0;
        start              = 1'b0;
        fwd_inv            = 1'b0;
        scale_sch          = '0;
        num_frames         = '0;
        stop               = 1'b0;
        s_axis_tdata       = DW'(32'h1234_5678);
        s_axis_tvalid      = 1'b1;
        s_axis_tlast       = 1'b0;
        m_axis_cfg_tready  = 1'b1;
        m_axis_data_tready = 1'b1;

        // Reset state with upstream valid high to expose any ungated path.
        repeat (3) @(posedge aclk);
        #1;
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_output("rst_cfg_tvalid", 64'(m_axis_cfg_tvalid), 64'd0);
        check_output("rst_cfg_tdata", 64'(m_axis_cfg_tdata), 64'd0);
        check_output("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check_output("rst_m_tvalid", 64'(m_axis_data_tvalid), 64'd0);
        check_output("rst_m_tdata", 64'(m_axis_data_tdata), 64'd0);
        check_output("rst_m_tlast", 64'(m_axis_data_tlast), 64'd0);
        check_output("rst_err_early", 64'(err_tlast_early), 64'd0);
        check_output("rst_err_missing", 64'(err_tlast_missing), 64'd0);
        aresetn = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
        check_output("idle_s_tready", 64'(s_axis_tready), 64'd0);

        // Two clean frames, no back-pressure, fixed config.
        $display("[TB] two-frame run");
        build_frames(2, -1);
        run_case("two_frames", 1'b1, 6'b101010, 2, -1, 1'b0, -1, 1'b0);
        check_output("cfg_word_literal", 64'(cfg_q[cfg_q.size() - 1]), 64'h005506);

        // Three frames under random back-pressure, random config, stray start.
        $display("[TB] back-pressure run");
        build_frames(3, -1);
        run_case("backpressure", 1'($urandom), SCALE_W'($urandom), 3, -1, 1'b0, 100, 1'b1);

        // Early upstream tlast at sample 40.
        $display("[TB] early tlast run");
        build_frames(1, 40);
        run_case("early_tlast", 1'b0, SCALE_W'($urandom), 1, -1, 1'b0, -1, 1'b0);

        // Continuous run stopped at sample 10 of the third frame.
        $display("[TB] continuous run with stop");
        build_frames(4, -1);
        run_case("stop_run", 1'b1, SCALE_W'($urandom), 0, 2 * N + 10, 1'b0, -1, 1'b1);

        // Start and stop together: exactly one frame.
        $display("[TB] start with stop");
        build_frames(2, -1);
        run_case("start_stop", 1'b0, SCALE_W'($urandom), 0, -1, 1'b1, -1, 1'b0);

        // Reset in the middle of a frame.
        $display("[TB] reset mid-frame");
        build_frames(1, -1);
        do_start(1'b1, SCALE_W'($urandom), 8'd1, 1'b0);
        apply_stimulus(-1, -1, 1'b0, 30, 500, consumed, finished);
        check_output("midrst_consumed", 64'(consumed), 64'd30);
        s_axis_tvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        check_output("midrst_busy", 64'(busy), 64'd0);
        check_output("midrst_m_tvalid", 64'(m_axis_data_tvalid), 64'd0);
        check_output("midrst_m_tlast", 64'(m_axis_data_tlast), 64'd0);
        check_output("midrst_m_tdata", 64'(m_axis_data_tdata), 64'd0);
        check_output("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        check_output("midrst_cfg_tdata", 64'(m_axis_cfg_tdata), 64'd0);
        check_output("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        s_axis_tvalid = 1'b0;
        in_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        build_frames(1, -1);
        run_case("after_reset", 1'b1, SCALE_W'($urandom), 1, -1, 1'b0, -1, 1'b0);

        check_output("done_busy_overlap", 64'(overlap_seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
